// File: rtl/truth_scan_pkg.sv
// Shared types and constants for the truth-table scanner: FSM states,
// vector/table widths and the input-vector-to-index mapping.
package truth_scan_pkg;

    localparam int unsigned IDX_W     = 5;
    localparam int unsigned TABLE_W   = 32;
    localparam int unsigned VEC_COUNT = 32;
    localparam int unsigned MCNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    // Vector index k = 16*s + 8*a + 4*b + 2*c + d
    function automatic logic [IDX_W-1:0] vec_to_idx(input logic s, input logic a,
                                                    input logic b, input logic c,
                                                    input logic d);
        return {s, a, b, c, d};
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-time down-counter: loads SETTLE_CYCLES-1, decrements on request,
// and flags zero so the scanner knows the current vector has settled.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 32 {s,a,b,c,d} vectors through the logic cone, samples o after a
// settle delay, and compares the captured truth table with a latched mask.
module truth_table_scanner
    import truth_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TABLE_W-1:0] expected,
    input  logic               o,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               s,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic [MCNT_W-1:0]  mismatch_cnt,
    output logic               pass
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    state_e             state;
    logic [IDX_W-1:0]   idx;
    logic [TABLE_W-1:0] exp_q;
    logic               load_c;
    logic               dec_c;
    logic               zero_c;

    // Stimulus comes straight off the index register
    assign {s, a, b, c, d} = idx;

    assign load_c = (state == IDLE && start) || (state == SAMPLE && idx != LAST_IDX);
    assign dec_c  = (state == SETTLE);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load_c),
        .dec   (dec_c),
        .zero_c(zero_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            exp_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q        <= expected;
                        table_out    <= '0;
                        mismatch_cnt <= '0;
                        pass         <= 1'b0;
                        idx          <= '0;
                        busy         <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (zero_c) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_out[idx] <= o;
                    if (o != exp_q[idx]) begin
                        mismatch_cnt <= mismatch_cnt + MCNT_W'(1);
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    // mismatch_cnt already includes the final sample here
                    pass  <= (mismatch_cnt == '0);
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: directed and random scans
// against a table-level reference model of the capture and compare.
module tb_truth_table_scanner;
    import truth_scan_pkg::*;

    localparam int unsigned SETTLE   = 4;
    localparam int unsigned PER_VEC  = SETTLE + 1;
    localparam int unsigned SCAN_CYC = PER_VEC * VEC_COUNT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] expected = '0;
    logic        o;
    logic        a, b, c, d, s;
    logic        busy, done, pass;
    logic [31:0] table_out;
    logic [5:0]  mismatch_cnt;

    logic [31:0] cone_tt = '0;
    int          o_mode = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Mode 1 loops o from s, mode 2 from d, otherwise o follows cone_tt
    assign o = (o_mode == 1) ? s :
               (o_mode == 2) ? d : cone_tt[vec_to_idx(s, a, b, c, d)];

    truth_table_scanner #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .expected    (expected),
        .o           (o),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .s           (s),
        .busy        (busy),
        .done        (done),
        .table_out   (table_out),
        .mismatch_cnt(mismatch_cnt),
        .pass        (pass)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference cone: s ? (a&b)|(c^d) : (a|~c)&d
    function automatic logic [31:0] golden_tt();
        logic [31:0] t;
        for (int k = 0; k < 32; k++) begin
            logic vs, va, vb, vc, vd;
            vs = ((k >> 4) & 1) != 0;
            va = ((k >> 3) & 1) != 0;
            vb = ((k >> 2) & 1) != 0;
            vc = ((k >> 1) & 1) != 0;
            vd = (k & 1) != 0;
            t[k] = vs ? ((va & vb) | (vc ^ vd)) : ((va | ~vc) & vd);
        end
        return t;
    endfunction

    task automatic run_scan(input string tag, input int mode, input logic [31:0] tt,
                            input logic [31:0] exp_tab, input bit disturb);
        int          hist[32];
        int          busy_cycles = 0;
        int          done_pulses = 0;
        int          late_busy = 0;
        int          bad_hold = 0;
        bit          seen_done = 0;
        int          exp_mis = 0;
        logic [31:0] model_exp;

        for (int k = 0; k < 32; k++) hist[k] = 0;
        o_mode    = mode;
        cone_tt   = tt;
        expected  = exp_tab;
        model_exp = exp_tab;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;

        for (int cyc = 0; cyc < int'(SCAN_CYC) + 20 && !seen_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (busy) begin
                busy_cycles++;
                hist[vec_to_idx(s, a, b, c, d)]++;
            end
            if (done) begin
                done_pulses++;
                seen_done = 1;
            end
            if (disturb) begin
                start = (busy && (busy_cycles == 20 || busy_cycles == 159)) || done;
                if (busy_cycles == 50) expected = ~exp_tab;
            end
        end
        check($sformatf("%s done_seen", tag), 64'(seen_done), 64'd1);
        check($sformatf("%s busy_cycles", tag), 64'(busy_cycles), 64'(SCAN_CYC));

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_pulses++;
            if (busy) late_busy++;
        end
        check($sformatf("%s done_pulses", tag), 64'(done_pulses), 64'd1);
        check($sformatf("%s idle_after", tag), 64'(late_busy), 64'd0);

        for (int k = 0; k < 32; k++) if (hist[k] != int'(PER_VEC)) bad_hold++;
        check($sformatf("%s vec_hold", tag), 64'(bad_hold), 64'd0);

        exp_mis = $countones(tt ^ model_exp);
        check($sformatf("%s table_out", tag), 64'(table_out), 64'(tt));
        check($sformatf("%s mismatch_cnt", tag), 64'(mismatch_cnt), 64'(exp_mis));
        check($sformatf("%s pass", tag), 64'(pass), 64'(exp_mis == 0));
        check($sformatf("%s stim_idle", tag), 64'({s, a, b, c, d}), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check($sformatf("%s busy", tag), 64'(busy), 64'd0);
        check($sformatf("%s done", tag), 64'(done), 64'd0);
        check($sformatf("%s table_out", tag), 64'(table_out), 64'd0);
        check($sformatf("%s mismatch_cnt", tag), 64'(mismatch_cnt), 64'd0);
        check($sformatf("%s pass", tag), 64'(pass), 64'd0);
        check($sformatf("%s stim", tag), 64'({s, a, b, c, d}), 64'd0);
    endtask

    initial begin
        logic [31:0] g;
        logic [31:0] rt;
        logic [31:0] re;
        int          dones;

        g = golden_tt();
        #8;
        check_reset_values("reset");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        run_scan("const0", 0, 32'h0000_0000, 32'h0000_0000, 0);
        run_scan("const1", 0, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_scan("loop_s", 1, 32'hFFFF_0000, 32'hFFFF_0000, 0);
        run_scan("loop_d", 2, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0);
        run_scan("golden_flip5", 0, g, g ^ 32'h0000_0020, 0);
        run_scan("disturb", 0, g, g, 1);

        // Reset in the middle of a scan
        o_mode   = 0;
        cone_tt  = g;
        expected = g;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (79) @(negedge clk);
        check("midrst busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst no_done", 64'(dones), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_scan("after_rst", 0, g, g, 0);

        for (int i = 0; i < 8; i++) begin
            rt = $urandom;
            case ($urandom_range(0, 2))
                0:       re = rt;
                1:       re = rt ^ (32'h1 << $urandom_range(0, 31));
                default: re = $urandom;
            endcase
            run_scan($sformatf("rand%0d", i), 0, rt, re, ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
